// File: rtl/ntt_result_reader.sv
// ntt_result_reader
// Streams a finished polynomial out of the NTT working BRAM. Each read
// fetches a pair of coefficients: even address on port A, odd address on
// port B. A small FIFO absorbs the one-cycle read latency and downstream
// stalls. When enabled, each coefficient gets one canonical correction
// into [0, Q).
module ntt_result_reader #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 8,
    parameter int N          = 256,
    parameter int Q          = 3329,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              canon_en,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] raddr_a,
    output logic [ADDR_W-1:0] raddr_b,
    input  logic [31:0]       dout_a,
    input  logic [31:0]       dout_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last
);

    localparam int PAIRS  = N / 2;
    localparam int PAIR_W = $clog2(PAIRS) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NEED_W = CNT_W + 2;

    // Modulus widened by two bits so that x+Q and x-Q cannot overflow
    localparam logic signed [WIDTH+1:0] Q_S = (WIDTH + 2)'(Q);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state_reg, state_next;

    logic [PAIR_W-1:0] pair_reg;      // read pairs issued so far
    logic              pending_reg;   // a read was issued last cycle
    logic              canon_reg;     // canon_en latched at start
    logic              done_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] out_idx_reg;   // index of the coefficient at the FIFO head

    logic [WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

    logic              issue;
    logic              done_set;
    logic              push;
    logic              pop;
    logic              drain_done;
    logic              space_ok;
    logic              start_accept;
    logic [NEED_W-1:0] need;
    logic [WIDTH-1:0]  lane_word [2];

    // Upper BRAM word bits carry nothing for this block
    logic unused_upper;
    assign unused_upper = ^{dout_a[31:WIDTH], dout_b[31:WIDTH]};

    // Slots needed if another read is issued now: the pair it brings plus
    // the pair still in flight. Pops in this cycle are deliberately not
    // credited, which keeps the check independent of m_ready.
    assign need     = {2'b00, count_reg} + (pending_reg ? NEED_W'(4) : NEED_W'(2));
    assign space_ok = (need <= NEED_W'(FIFO_DEPTH));

    assign start_accept = (state_reg == ST_IDLE) && start;
    assign push         = pending_reg;
    assign m_valid      = (count_reg != '0);
    assign pop          = m_valid && m_ready;

    // The FIFO is empty after this edge and nothing more can arrive
    assign drain_done = !pending_reg &&
                        ((count_reg == '0) || ((count_reg == CNT_W'(1)) && pop));

    // Next-state logic plus read-issue and completion decodes
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        done_set   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pair_reg == PAIR_W'(PAIRS)) begin
                    state_next = ST_DRAIN;
                end else if (space_ok) begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_next = ST_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Run control: pair counter, in-flight flag, latched mode, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_reg    <= '0;
            pending_reg <= 1'b0;
            canon_reg   <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            pending_reg <= issue;
            done_reg    <= done_set;
            if (start_accept) begin
                canon_reg <= canon_en;
                pair_reg  <= '0;
            end else if (issue) begin
                pair_reg <= pair_reg + PAIR_W'(1);
            end
        end
    end

    // FIFO pointers, occupancy and output index; a push adds two entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            out_idx_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(2);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + (push ? CNT_W'(2) : CNT_W'(0))
                                   - (pop  ? CNT_W'(1) : CNT_W'(0));
            if (start_accept) begin
                out_idx_reg <= '0;
            end else if (pop) begin
                out_idx_reg <= out_idx_reg + ADDR_W'(1);
            end
        end
    end

    assign lane_word[0] = dout_a[WIDTH-1:0];
    assign lane_word[1] = dout_b[WIDTH-1:0];

    // One canonical-correction lane per BRAM port
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [WIDTH+1:0] x_ext;
            logic [WIDTH-1:0]        res;

            assign x_ext = {{2{lane_word[gi][WIDTH-1]}}, lane_word[gi]};

            // Single correction toward [0, Q) when the run asked for it
            always_comb begin
                res = lane_word[gi];
                if (canon_reg) begin
                    if (x_ext < 0) begin
                        res = WIDTH'(x_ext + Q_S);
                    end else if (x_ext >= Q_S) begin
                        res = WIDTH'(x_ext - Q_S);
                    end
                end
            end
        end
    endgenerate

    // FIFO storage: port A word lands first, port B word right behind it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg]              <= g_lane[0].res;
            fifo_mem[wr_ptr_reg + PTR_W'(1)]  <= g_lane[1].res;
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign rd_en   = issue;
    assign raddr_a = issue ? ADDR_W'({pair_reg, 1'b0}) : '0;
    assign raddr_b = issue ? ADDR_W'({pair_reg, 1'b1}) : '0;
    assign m_data  = m_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign m_index = out_idx_reg;
    assign m_last  = m_valid && (out_idx_reg == ADDR_W'(N - 1));

endmodule

// File: tb/tb_ntt_result_reader.sv
// Self-checking bench for ntt_result_reader: a BRAM model feeds the DUT,
// a queue-free reference computes every expected coefficient from the
// stored words, and a negedge monitor checks each beat and the protocol.
module tb_ntt_result_reader;

    localparam int WIDTH      = 16;
    localparam int ADDR_W     = 8;
    localparam int N          = 256;
    localparam int Q          = 3329;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              canon_en = 1'b0;
    logic              m_ready = 1'b0;
    logic              busy, done, rd_en, m_valid, m_last;
    logic [ADDR_W-1:0] raddr_a, raddr_b, m_index;
    logic [WIDTH-1:0]  m_data;
    logic [31:0]       dout_a, dout_b;

    always #5 clk = ~clk;

    ntt_result_reader #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .N(N), .Q(Q), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .canon_en(canon_en),
        .busy(busy), .done(done), .rd_en(rd_en),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .dout_a(dout_a), .dout_b(dout_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last)
    );

    // BRAM model with one-cycle read latency
    logic [31:0] bram [N];
    always @(posedge clk) begin
        if (rd_en) begin
            dout_a <= bram[raddr_a];
            dout_b <= bram[raddr_b];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference coefficient: low 16 bits as signed, optional single correction
    function automatic logic [15:0] ref_coeff(input logic [31:0] w, input bit canon);
        int v;
        v = int'($signed(w[15:0]));
        if (canon) begin
            if (v < 0) v = v + Q;
            else if (v >= Q) v = v - Q;
        end
        return v[15:0];
    endfunction

    logic [15:0] exp_data [N];
    logic [15:0] got_data [N];

    // Downstream ready: 0 = always ready, 1 = ~30% duty, 2 = never ready
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 99) < 30);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor state
    int cyc = 0;
    int beats = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int last_hs_cyc = 0;
    int gaps = 0;
    int done_cnt = 0;
    int reads = 0;
    int occ = 0;
    bit rd_prev = 0;
    bit streaming = 0;
    bit prev_valid = 0;
    bit prev_ready = 0;
    logic [WIDTH-1:0]  prev_data;
    logic [ADDR_W-1:0] prev_idx;

    // Per-cycle protocol and data checks, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            beats = 0; occ = 0; rd_prev = 0; prev_valid = 0; prev_ready = 0;
            streaming = 0; reads = 0; first_valid_cyc = -1;
        end else begin
            if (start && !busy) begin
                start_cyc = cyc; beats = 0; first_valid_cyc = -1; gaps = 0;
                done_cnt = 0; reads = 0; streaming = 1;
            end
            if (prev_valid && !prev_ready) begin
                check_val("hold_valid", m_valid, 1);
                check_val("hold_data", m_data, prev_data);
                check_val("hold_index", m_index, prev_idx);
            end
            if (streaming && first_valid_cyc >= 0 && !m_valid) gaps++;
            if (streaming && m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rd_en) reads++;
            if (m_valid && m_ready) begin
                if (beats < N) begin
                    check_val("beat_data", m_data, exp_data[beats]);
                    check_val("beat_index", m_index, beats);
                    check_val("beat_last", m_last, (beats == N - 1));
                    got_data[beats] = m_data;
                end else begin
                    check_val("beat_overrun", beats, N - 1);
                end
                beats++;
                last_hs_cyc = cyc;
                if (m_last) streaming = 0;
            end
            if (done) begin
                done_cnt++;
                check_val("done_latency", cyc - last_hs_cyc, 1);
                check_val("busy_at_done", busy, 0);
            end
            occ = occ + (rd_prev ? 2 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (rd_prev) check_val("fifo_space", (occ <= FIFO_DEPTH), 1);
            rd_prev    = rd_en;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
        end
    end

    task automatic fill_random(input bit canon);
        for (int i = 0; i < N; i++) begin
            logic [31:0] r;
            int v;
            r = $urandom();
            if (canon && $urandom_range(0, 9) != 0) begin
                v = int'($urandom_range(0, 3 * Q - 2)) - (Q - 1);
                r[15:0] = v[15:0];
            end
            bram[i] = r;
            exp_data[i] = ref_coeff(r, canon);
        end
    endtask

    // canon_en is flipped after the pulse to confirm it is latched at start
    task automatic start_run(input bit canon);
        @(posedge clk); #1;
        canon_en = canon;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        canon_en = ~canon;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check_val({tag, "_done_seen"}, (done_cnt > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_beats"}, beats, N);
        check_val({tag, "_done_once"}, done_cnt, 1);
        check_val({tag, "_idle_busy"}, busy, 0);
        $display("run %s: %0d beats, %0d done pulses", tag, beats, done_cnt);
    endtask

    task automatic wait_beats(input int k);
        int t;
        t = 0;
        while (beats < k && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check_val("beats_reached", (beats >= k), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_rd_en"}, rd_en, 0);
        check_val({tag, "_raddr_a"}, raddr_a, 0);
        check_val({tag, "_raddr_b"}, raddr_b, 0);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_data"}, m_data, 0);
        check_val({tag, "_m_index"}, m_index, 0);
        check_val({tag, "_m_last"}, m_last, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) bram[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Identity data, full throughput
        for (int i = 0; i < N; i++) begin
            bram[i] = i;
            exp_data[i] = ref_coeff(bram[i], 1'b0);
        end
        ready_mode = 0;
        start_run(1'b0);
        wait_done("identity");
        check_val("first_valid_latency", first_valid_cyc - start_cyc, 3);
        check_val("no_stall_gaps", gaps, 0);

        // Canonical reduction corner values
        fill_random(1'b1);
        bram[0] = 32'h0000_FFFB;
        bram[1] = 32'd3330;
        bram[2] = 32'd3328;
        bram[3] = 32'h0001_0007;
        for (int i = 0; i < 4; i++) exp_data[i] = ref_coeff(bram[i], 1'b1);
        start_run(1'b1);
        wait_done("canon");
        check_val("canon_neg", got_data[0], 3324);
        check_val("canon_over", got_data[1], 1);
        check_val("canon_inrange", got_data[2], 3328);
        check_val("canon_upper_bits", got_data[3], 7);

        // Random backpressure, both modes
        ready_mode = 1;
        for (int k = 0; k < 2; k++) begin
            bit c;
            c = (k == 1);
            fill_random(c);
            start_run(c);
            wait_done(c ? "bp_canon" : "bp_raw");
        end

        // Long stall right after start
        ready_mode = 2;
        fill_random(1'b0);
        start_run(1'b0);
        repeat (50) @(posedge clk);
        #1;
        check_val("stall_reads_bounded", (reads <= FIFO_DEPTH / 2), 1);
        check_val("stall_valid_held", m_valid, 1);
        check_val("stall_index0", m_index, 0);
        ready_mode = 0;
        wait_done("stall_release");

        // Second start mid-stream is ignored
        ready_mode = 1;
        fill_random(1'b1);
        start_run(1'b1);
        wait_beats(100);
        @(posedge clk); #1;
        start = 1'b1;
        canon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart_ignored");

        // Asynchronous reset mid-run, then a fresh run
        ready_mode = 0;
        fill_random(1'b0);
        start_run(1'b0);
        wait_beats(60);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_random(1'b1);
        start_run(1'b1);
        wait_done("after_reset");
        check_val("after_reset_latency", first_valid_cyc - start_cyc, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
